// File: rtl/gerador_pkg.sv
// Shared definitions for button front-ends that issue soma/sub/enp step commands.
// Holds the FSM state encodings and the default timing constants.
package gerador_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    FILTRA = 3'd1,
    PULSO  = 3'd2,
    SEGURA = 3'd3,
    REPETE = 3'd4,
    SOLTA  = 3'd5
  } estado_t;

  localparam int unsigned DEBOUNCE_PADRAO = 32'd500000;
  localparam int unsigned HOLD_PADRAO     = 32'd25000000;
  localparam int unsigned REPEAT_PADRAO   = 32'd10000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for one asynchronous level input.
// Both stages clear to 0 on the asynchronous active-low reset.
module sincronizador_2ff (
  input  logic clock,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sinc_r;

  // metastability stage followed by the stable output stage
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      meta_r <= 1'b0;
      sinc_r <= 1'b0;
    end else begin
      meta_r <= d;
      sinc_r <= meta_r;
    end
  end

  assign q = sinc_r;

endmodule

// File: rtl/gerador_soma_sub.sv
// Turns two raw bouncing buttons into clean single-cycle up/down step strobes,
// with press/release debounce and optional auto-repeat while a button is held.
module gerador_soma_sub
  import gerador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
  parameter int unsigned HOLD_CYCLES     = HOLD_PADRAO,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_PADRAO,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clock,
  input  logic clr,
  input  logic botao_mais,
  input  logic botao_menos,
  input  logic habilita,
  output logic soma,
  output logic sub,
  output logic enp,
  output logic ocupado
);

  localparam int unsigned MAX_CYC = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CW      = (MAX_CYC > 32'd2) ? $clog2(MAX_CYC) : 32'd1;

  // Hold and repeat terminals are two short: one cycle is spent in PULSO and
  // one on the entry edge into SEGURA/REPETE, so the pulse spacing is exact.
  localparam logic [CW-1:0] DEB_FIM  = CW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CW-1:0] HOLD_FIM = CW'(HOLD_CYCLES - 32'd2);
  localparam logic [CW-1:0] REP_FIM  = CW'(REPEAT_CYCLES - 32'd2);

  logic          mais_s;
  logic          menos_s;
  logic          pedido_s;
  logic          mantido_s;
  logic          entra_s;
  logic          pulso_s;
  estado_t       estado_r;
  estado_t       estado_prox_s;
  logic [CW-1:0] cont_r;
  logic [CW-1:0] cont_prox_s;
  logic          dir_r;
  logic          dir_prox_s;
  logic          rep_r;
  logic          rep_prox_s;
  logic          soma_r;
  logic          sub_r;
  logic          enp_r;
  logic          ocupado_r;

  sincronizador_2ff u_sinc_mais (
    .clock (clock),
    .clr   (clr),
    .d     (botao_mais),
    .q     (mais_s)
  );

  sincronizador_2ff u_sinc_menos (
    .clock (clock),
    .clr   (clr),
    .d     (botao_menos),
    .q     (menos_s)
  );

  assign pedido_s  = mais_s ^ menos_s;
  assign mantido_s = dir_r ? (mais_s & ~menos_s) : (menos_s & ~mais_s);

  // next-state, counter and direction/repeat bookkeeping
  always_comb begin
    estado_prox_s = estado_r;
    cont_prox_s   = cont_r + CW'(1);
    dir_prox_s    = dir_r;
    rep_prox_s    = rep_r;
    case (estado_r)
      OCIOSO: begin
        cont_prox_s = '0;
        if (pedido_s) begin
          estado_prox_s = FILTRA;
          dir_prox_s    = mais_s;
        end else begin
          estado_prox_s = OCIOSO;
        end
      end
      FILTRA: begin
        if (!mantido_s) begin
          estado_prox_s = OCIOSO;
        end else if (cont_r == DEB_FIM) begin
          estado_prox_s = PULSO;
          rep_prox_s    = 1'b0;
        end else begin
          estado_prox_s = FILTRA;
        end
      end
      PULSO: begin
        if (!REPEAT_EN) begin
          estado_prox_s = SOLTA;
        end else if (rep_r) begin
          estado_prox_s = REPETE;
        end else begin
          estado_prox_s = SEGURA;
        end
      end
      SEGURA: begin
        if (!mantido_s) begin
          estado_prox_s = SOLTA;
        end else if (cont_r == HOLD_FIM) begin
          estado_prox_s = PULSO;
          rep_prox_s    = 1'b1;
        end else begin
          estado_prox_s = SEGURA;
        end
      end
      REPETE: begin
        if (!mantido_s) begin
          estado_prox_s = SOLTA;
        end else if (cont_r == REP_FIM) begin
          estado_prox_s = PULSO;
          rep_prox_s    = 1'b1;
        end else begin
          estado_prox_s = REPETE;
        end
      end
      SOLTA: begin
        if (mais_s | menos_s) begin
          estado_prox_s = SOLTA;
          cont_prox_s   = '0;
        end else if (cont_r == DEB_FIM) begin
          estado_prox_s = OCIOSO;
        end else begin
          estado_prox_s = SOLTA;
        end
      end
      default: begin
        estado_prox_s = OCIOSO;
        cont_prox_s   = '0;
      end
    endcase
  end

  assign entra_s = (estado_prox_s != estado_r);
  assign pulso_s = (estado_prox_s == PULSO);

  // FSM state, counter and latched direction
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      estado_r <= OCIOSO;
      cont_r   <= '0;
      dir_r    <= 1'b0;
      rep_r    <= 1'b0;
    end else begin
      estado_r <= estado_prox_s;
      cont_r   <= entra_s ? '0 : cont_prox_s;
      dir_r    <= dir_prox_s;
      rep_r    <= rep_prox_s;
    end
  end

  // Strobes are decoded from the next state so enp is high exactly while in PULSO
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      enp_r     <= 1'b0;
      soma_r    <= 1'b0;
      sub_r     <= 1'b0;
      ocupado_r <= 1'b0;
    end else begin
      enp_r     <= pulso_s & habilita;
      soma_r    <= pulso_s & habilita & dir_prox_s;
      sub_r     <= pulso_s & habilita & ~dir_prox_s;
      ocupado_r <= (estado_r != OCIOSO);
    end
  end

  assign enp     = enp_r;
  assign soma    = soma_r;
  assign sub     = sub_r;
  assign ocupado = ocupado_r;

endmodule

// File: doc/gerador_soma_sub.md
Name: gerador_soma_sub

Overview:
- Command initiator for the drone position/mode up-down counters. Its outputs connect directly to the counter's soma, sub and enp inputs.
- Converts two raw, bouncing push-buttons into clean single-cycle step pulses.
- Functions: 2-flop synchronisation, press and release debounce, optional auto-repeat while a button is held.
- Sits between the board button pins and any mod-N up/down counter in the datapath.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a press or a release; minimum 2.
- HOLD_CYCLES, 25000000: cycles from the first pulse to the first auto-repeat pulse.
- REPEAT_CYCLES, 10000000: period between successive auto-repeat pulses; minimum 2.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clr  in  1  asynchronous, active-low reset.
- botao_mais  in  1  raw increment button, active-high, asynchronous to clock.
- botao_menos  in  1  raw decrement button, active-high, asynchronous to clock.
- habilita  in  1  1 = pulses allowed; 0 = pulses suppressed.
- soma  out  1  registered; high only together with enp, direction up.
- sub  out  1  registered; high only together with enp, direction down.
- enp  out  1  registered one-cycle step strobe.
- ocupado  out  1  registered; high whenever the FSM is not in OCIOSO.

Behaviour:
- Reset: clr=0 asynchronously clears both synchroniser stages, the FSM (to OCIOSO), the counter, the direction latch, soma, sub, enp and ocupado. Assertion mid-press drops any pending pulse. A button still held after release of clr must pass the full FILTRA debounce before a pulse is issued.
- Synchroniser: two flops per button, giving sincronizado mais_s and menos_s (2-cycle latency). The FSM sees only the synchronised signals.
- Valid request: exactly one of mais_s and menos_s is high. Both high is treated as no request.
- Counter: one internal counter, width = clog2 of the largest of the three cycle parameters. It is cleared on every state entry.
- OCIOSO:
  - All outputs 0.
  - On a valid request: latch dir (1=mais, 0=menos) and go to FILTRA.
- FILTRA:
  - While the latched button alone stays high, count up.
  - When count = DEBOUNCE_CYCLES-1, go to PULSO.
  - Any other input combination returns to OCIOSO.
- PULSO:
  - Lasts exactly one cycle.
  - enp = habilita; soma = habilita AND dir; sub = habilita AND NOT dir.
  - Next state: SEGURA if this was the first pulse of the press and REPEAT_EN=1; REPETE if it was a repeat pulse; SOLTA if REPEAT_EN=0.
- SEGURA:
  - Count while the latched button alone stays high.
  - Go to PULSO so that the first repeat pulse occurs exactly HOLD_CYCLES cycles after the first pulse.
  - Loss of a valid request goes to SOLTA.
- REPETE:
  - Same structure as SEGURA.
  - Go to PULSO so that the spacing between repeat pulses is exactly REPEAT_CYCLES cycles.
- SOLTA:
  - Requires both synchronised buttons low for DEBOUNCE_CYCLES consecutive cycles, then go to OCIOSO.
  - Any high input restarts the count.
  - No pulses are emitted in this state.
- Latency: if a raw press is first sampled at edge 0 and held clean, enp is high for the single cycle following edge DEBOUNCE_CYCLES+2.
- Pulse rules:
  - soma and sub are never both high.
  - Neither soma nor sub is ever high without enp.
  - enp is never high for two consecutive cycles.
- Direction change while held: the latched direction loses its valid request, so the FSM goes through SOLTA. The new button is acted on only after a full release.
- habilita=0: the FSM keeps running and timing is unchanged, but the PULSO cycle produces no outputs. Raising habilita mid-hold allows the next repeat pulse.
- ocupado = (state != OCIOSO), registered.

Decomposition:
- Shared package gerador_pkg:
  - state encodings OCIOSO, FILTRA, PULSO, SEGURA, REPETE, SOLTA (3-bit localparams);
  - default timing constants, for reuse by other button front-ends.
- One natural sub-module: sincronizador_2ff, 1-bit, with clock and clr. It is instantiated twice.

Test Plan (overrides DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8):
- Clean botao_mais press held 10 cycles, first sampled at edge 0 -> a single enp=1/soma=1/sub=0 cycle after edge 6; ocupado falls 4+2 cycles after release is synchronised.
- botao_menos bouncing 1-0-1 every 2 cycles for 12 cycles, then stable high -> no pulse during the bounce; exactly one sub pulse 6 cycles after the last rising bounce.
- botao_mais held 60 cycles with REPEAT_EN=1 -> pulses after edges 6, 22, 30, 38, 46, 54, then no more; with REPEAT_EN=0 -> only the pulse after edge 6.
- Both buttons pressed together for 20 cycles -> no pulse, ocupado stays 0. Press mais, then add menos mid-SEGURA -> no further pulses until both are released.
- habilita=0 during a 30-cycle hold -> enp/soma/sub stay 0 throughout; habilita raised at edge 20 -> next repeat pulse after edge 22.
- clr pulsed low during FILTRA -> all outputs 0 immediately, no pulse; button still held afterward -> pulse 4+2+1 cycles after clr release.
